// File: rtl/playseq_pkg.sv
// playseq_pkg: state codes, debounce defaults and the one-hot helper
// shared by the PlaySeq button-input conditioner.
package playseq_pkg;

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        FILTRA_PRESS = 3'd1,
        ACEITA       = 3'd2,
        ESPERA_SOLTA = 3'd3,
        FILTRA_SOLTA = 3'd4
    } estado_t;

    localparam int DEBOUNCE_DEFAULT = 1000;
    localparam int CNT_W_DEFAULT    = 10;

    function automatic logic one_hot4(input logic [3:0] p);
        return (p != 4'b0000) && ((p & (p - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/playseq_sincronizador.sv
// playseq_sincronizador: per-bit input synchroniser.
// PLAYSEQ_SYNC2_EN selects a 2-flop chain; otherwise a single flop.
module playseq_sincronizador #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

`ifdef PLAYSEQ_SYNC2_EN
    logic [W-1:0] meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
`else
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end
`endif

endmodule

// File: rtl/playseq_detector_jogada.sv
// playseq_detector_jogada: debounces the four player buttons and reports
// one accepted press per release. Synchroniser depth set by PLAYSEQ_SYNC2_EN.
module playseq_detector_jogada
    import playseq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       limpa,
    input  logic [3:0] botoes,
    output logic       tem_jogada,
    output logic [3:0] jogada,
    output logic       jogada_invalida,
    output logic [2:0] db_estado
);

    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);

    logic [3:0]       b_s;
    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       padrao_q, padrao_d;
    logic [3:0]       jogada_d;
    logic             inval_d;

    playseq_sincronizador #(.W(4)) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (b_s)
    );

    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_UM;
    assign db_estado = estado_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q        <= OCIOSO;
            cnt_q           <= '0;
            padrao_q        <= '0;
            jogada          <= '0;
            jogada_invalida <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            cnt_q           <= cnt_d;
            padrao_q        <= padrao_d;
            jogada          <= jogada_d;
            jogada_invalida <= inval_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        padrao_d   = padrao_q;
        jogada_d   = jogada;
        inval_d    = jogada_invalida;
        tem_jogada = 1'b0;

        // ACEITA below overrides a coincident clear
        if (limpa) begin
            jogada_d = '0;
            inval_d  = 1'b0;
        end

        case (estado_q)
            OCIOSO: begin
                cnt_d = '0;
                if (b_s != 4'b0000) begin
                    if (habilita) begin
                        padrao_d = b_s;
                        estado_d = FILTRA_PRESS;
                    end else begin
                        estado_d = ESPERA_SOLTA;
                    end
                end
            end
            FILTRA_PRESS: begin
                if (b_s == 4'b0000) begin
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end else if (b_s != padrao_q) begin
                    padrao_d = b_s;
                    cnt_d    = '0;
                end else if (cnt_q >= CNT_FIM) begin
                    estado_d = ACEITA;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ACEITA: begin
                tem_jogada = 1'b1;
                jogada_d   = padrao_q;
                inval_d    = !one_hot4(padrao_q);
                estado_d   = ESPERA_SOLTA;
                cnt_d      = '0;
            end
            ESPERA_SOLTA: begin
                cnt_d = '0;
                if (b_s == 4'b0000) begin
                    estado_d = FILTRA_SOLTA;
                end
            end
            FILTRA_SOLTA: begin
                if (b_s != 4'b0000) begin
                    estado_d = ESPERA_SOLTA;
                    cnt_d    = '0;
                end else if (cnt_q >= CNT_FIM) begin
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                estado_d = OCIOSO;
                cnt_d    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_playseq_detector_jogada.sv
// tb_playseq_detector_jogada: directed vectors for the button conditioner
// with DEBOUNCE_CYCLES=4; pulse timing follows the synchroniser depth.
module tb_playseq_detector_jogada;

`ifdef PLAYSEQ_SYNC2_EN
    localparam int SL = 2;
`else
    localparam int SL = 1;
`endif
    localparam int D   = 4;
    localparam int LAT = SL + D + 1;

    logic       clock;
    logic       reset;
    logic       habilita;
    logic       limpa;
    logic [3:0] botoes;
    logic       tem_jogada;
    logic [3:0] jogada;
    logic       jogada_invalida;
    logic [2:0] db_estado;

    int n_checks;
    int n_fail;
    int cyc;
    int n_pulse;
    int pulse_cyc;
    logic [3:0] jog_at_pulse;
    int c0;

    playseq_detector_jogada #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .limpa           (limpa),
        .botoes          (botoes),
        .tem_jogada      (tem_jogada),
        .jogada          (jogada),
        .jogada_invalida (jogada_invalida),
        .db_estado       (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            cyc++;
            if (tem_jogada === 1'b1) begin
                n_pulse++;
                pulse_cyc    = cyc;
                jog_at_pulse = jogada;
            end
        end
    endtask

    task automatic idle_out();
        botoes = 4'b0000;
        step(3 * D + 6);
        n_pulse = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        n_pulse  = 0;
        pulse_cyc = 0;
        jog_at_pulse = '0;
        reset    = 1'b0;
        habilita = 1'b1;
        limpa    = 1'b0;
        botoes   = 4'b0000;
        step(3);
        chk("rst_estado", 32'(db_estado), 32'd0);
        chk("rst_tem", 32'(tem_jogada), 32'd0);
        chk("rst_jogada", 32'(jogada), 32'd0);
        chk("rst_inval", 32'(jogada_invalida), 32'd0);
        reset = 1'b1;
        step(2);

        // reset mid-filter, button still held across release
        botoes = 4'b0010;
        step(SL + 2);
        chk("midfilt_estado", 32'(db_estado), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_estado", 32'(db_estado), 32'd0);
        chk("async_rst_tem", 32'(tem_jogada), 32'd0);
        chk("async_rst_jogada", 32'(jogada), 32'd0);
        n_pulse = 0;
        step(2);
        reset = 1'b1;
        c0 = cyc;
        step(LAT + 6);
        chk("rst_rel_npulse", 32'(n_pulse), 32'd1);
        chk("rst_rel_pcyc", 32'(pulse_cyc - c0), 32'(LAT));
        chk("rst_rel_jogada", 32'(jogada), 32'h2);
        idle_out();

        // clean press held 20 cycles
        c0 = cyc;
        botoes = 4'b0100;
        step(20);
        chk("clean_npulse", 32'(n_pulse), 32'd1);
        chk("clean_pcyc", 32'(pulse_cyc - c0), 32'(LAT));
        chk("clean_jogada", 32'(jogada), 32'h4);
        chk("clean_inval", 32'(jogada_invalida), 32'd0);
        chk("clean_hold_estado", 32'(db_estado), 32'd3);
        // short release then re-press: must not retrigger
        botoes = 4'b0000;
        step(3);
        botoes = 4'b0100;
        step(20);
        chk("short_rel_npulse", 32'(n_pulse), 32'd1);
        idle_out();
        chk("idle_estado", 32'(db_estado), 32'd0);
        chk("idle_jogada_hold", 32'(jogada), 32'h4);

        // bounce: 0100/0000 every 2 cycles, then hold
        c0 = cyc;
        for (int i = 0; i < 5; i++) begin
            botoes = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            step(2);
        end
        botoes = 4'b0100;
        step(LAT + 8);
        chk("bounce_npulse", 32'(n_pulse), 32'd1);
        chk("bounce_pcyc", 32'(pulse_cyc - c0), 32'(8 + LAT));
        idle_out();

        // press while disabled, enable raised while held
        habilita = 1'b0;
        botoes = 4'b0001;
        step(5);
        habilita = 1'b1;
        step(15);
        chk("dis_npulse", 32'(n_pulse), 32'd0);
        chk("dis_estado", 32'(db_estado), 32'd3);
        idle_out();
        c0 = cyc;
        botoes = 4'b1000;
        step(15);
        chk("en_npulse", 32'(n_pulse), 32'd1);
        chk("en_pcyc", 32'(pulse_cyc - c0), 32'(LAT));
        chk("en_jogada", 32'(jogada), 32'h8);
        idle_out();

        // non one-hot pattern, then clear
        botoes = 4'b0011;
        step(15);
        chk("inv_npulse", 32'(n_pulse), 32'd1);
        chk("inv_jogada", 32'(jogada), 32'h3);
        chk("inv_flag", 32'(jogada_invalida), 32'd1);
        idle_out();
        chk("inv_hold", 32'(jogada_invalida), 32'd1);
        limpa = 1'b1;
        step(1);
        limpa = 1'b0;
        chk("limpa_jogada", 32'(jogada), 32'd0);
        chk("limpa_inval", 32'(jogada_invalida), 32'd0);

        // pattern change while filtering
        c0 = cyc;
        botoes = 4'b0001;
        step(2);
        botoes = 4'b0010;
        step(15);
        chk("chg_npulse", 32'(n_pulse), 32'd1);
        chk("chg_pcyc", 32'(pulse_cyc - c0), 32'(2 + LAT));
        chk("chg_jogada", 32'(jogada), 32'h2);
        idle_out();

        // accept wins over a coincident clear
        limpa = 1'b1;
        botoes = 4'b1000;
        step(15);
        chk("prio_npulse", 32'(n_pulse), 32'd1);
        chk("prio_at_pulse", 32'(jog_at_pulse), 32'd0);
        chk("prio_after", 32'(jogada), 32'd0);
        limpa = 1'b0;
        idle_out();
        c0 = cyc;
        botoes = 4'b0001;
        limpa = 1'b0;
        step(LAT);
        limpa = 1'b1;
        step(1);
        limpa = 1'b0;
        chk("prio2_npulse", 32'(n_pulse), 32'd1);
        chk("prio2_jogada", 32'(jogada), 32'h1);
        idle_out();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/playseq_detector_jogada.md
Name: playseq_detector_jogada

Overview:
Input conditioner that sits directly upstream of the PlaySeq control unit and feeds its tem_jogada input. It synchronises and debounces the four player buttons, accepts one press per release, and registers the pressed button as a one-hot jogada for the datapath comparator. Presses are accepted only while the control unit enables capture.

Parameters:
DEBOUNCE_CYCLES, 1000, cycles a button pattern must stay stable before it is accepted (min 2)
CNT_W, 10, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low
habilita  in  1  capture enable from control unit (high while waiting for a play)
limpa  in  1  synchronous clear of jogada/jogada_invalida
botoes  in  4  raw buttons, active-high, asynchronous to clock
tem_jogada  out  1  one-cycle pulse: valid press accepted
jogada  out  4  registered one-hot button of the last accepted press
jogada_invalida  out  1  last accepted pattern was not one-hot
db_estado  out  3  current FSM state code

Behaviour:
- Reset (reset=0, async): state OCIOSO, counter 0, tem_jogada=0, jogada=4'b0000, jogada_invalida=0, synchroniser flops 0.
- botoes pass through the synchroniser to give b_s; all FSM decisions use b_s. Latency from a raw edge to b_s: 2 cycles (1 without the macro).
- States and db_estado codes:
  - OCIOSO (0): counter=0. If b_s!=0 and habilita=1, latch pattern p=b_s and go to FILTRA_PRESS. If b_s!=0 and habilita=0, go to ESPERA_SOLTA, so a press held from a disabled period is never accepted.
  - FILTRA_PRESS (1): if b_s==p, counter++. If b_s!=p and b_s!=0, reload p=b_s and clear the counter. If b_s==0, return to OCIOSO. When counter reaches DEBOUNCE_CYCLES-1 with b_s==p, go to ACEITA.
  - ACEITA (2): tem_jogada=1 for exactly this cycle. jogada<=p. jogada_invalida<=(p not one-hot). Go to ESPERA_SOLTA. This applies even if habilita fell during filtering, because the enable is sampled only in OCIOSO.
  - ESPERA_SOLTA (3): counter=0 while b_s!=0. When b_s==0, go to FILTRA_SOLTA.
  - FILTRA_SOLTA (4): counter++ while b_s==0. Any b_s!=0 returns to ESPERA_SOLTA. At DEBOUNCE_CYCLES-1, go to OCIOSO.
- Outputs are Moore and registered. Only tem_jogada is combinational from state. jogada and jogada_invalida hold until the next ACEITA or until limpa.
- limpa=1 sets jogada=0 and jogada_invalida=0 next edge. If limpa and ACEITA coincide, ACEITA wins.
- Counter saturates and never wraps. Unused state codes go to OCIOSO.
- Minimum interval between two tem_jogada pulses: 2*DEBOUNCE_CYCLES+2 cycles after the synchroniser.

Optional Feature:
PLAYSEQ_SYNC2_EN: when defined, the synchroniser is a 2-flop chain per bit (latency 2). When undefined, it is a single flop (latency 1); use this for fast simulation only. FSM behaviour is otherwise identical.

Decomposition:
- Shared package playseq_pkg:
  - State encodings OCIOSO..FILTRA_SOLTA (3-bit).
  - Default DEBOUNCE_CYCLES.
  - Function one_hot4(p) giving the one-hot check.
- One natural sub-module, playseq_sincronizador. It is parameterised on width and holds the synchroniser chain, with the macro selecting its depth.

Test Plan:
- Reset and idle: assert reset=0 mid-filter with botoes=4'b0010. Require all outputs 0, db_estado=0 immediately, and no pulse after release of reset until a fresh full debounce.
- Clean press: DEBOUNCE_CYCLES=4, habilita=1, botoes=4'b0100 held 20 cycles. Require a single tem_jogada pulse at cycle sync+4+1 and jogada=4'b0100. Require no second pulse until release plus 4 stable-low cycles.
- Bounce: botoes toggles 0100/0000 every 2 cycles for 10 cycles, then holds. Require exactly one pulse, only after 4 stable cycles.
- Disabled press: habilita=0, press 0001, raise habilita while still held. Require no pulse. Release, then press 1000: require a pulse and jogada=4'b1000.
- Invalid pattern: press 4'b0011 stable. Require a pulse, jogada=4'b0011 and jogada_invalida=1. Then limpa=1: require jogada=0 and jogada_invalida=0 next cycle.
- Pattern change during filter: 0001 for 2 cycles, then 0010 stable. Require a single pulse with jogada=4'b0010.
